// File: rtl/sine_mix_pkg.sv
// rtl/sine_mix_pkg.sv - shared FSM encoding and frame-length limits for the sine mixer framer
package sine_mix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int unsigned FRAME_LEN_MIN = 2;
    localparam int unsigned FRAME_LEN_MAX = 1023;
    localparam int unsigned CNT_WIDTH     = 10;

endpackage

// File: rtl/signed_mult_pipe.sv
// rtl/signed_mult_pipe.sv - two-stage full-precision signed multiplier with valid/sof/eof sideband
module signed_mult_pipe #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 32,
    parameter int P_WIDTH = 48
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic                      in_eof,
    output logic signed [P_WIDTH-1:0] p,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic                      out_eof
);

    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;
    logic                      v_q;
    logic                      sof_q;
    logic                      eof_q;
    logic signed [P_WIDTH-1:0] a_ext;
    logic signed [P_WIDTH-1:0] b_ext;

    // Widen both operands to the product width so the multiply is exact.
    assign a_ext = {{(P_WIDTH-A_WIDTH){a_q[A_WIDTH-1]}}, a_q};
    assign b_ext = {{(P_WIDTH-B_WIDTH){b_q[B_WIDTH-1]}}, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            v_q       <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            v_q     <= in_valid;
            sof_q   <= in_valid & in_sof;
            eof_q   <= in_valid & in_eof;
            if (in_valid) begin
                a_q <= a;
                b_q <= b;
            end
            out_valid <= v_q;
            out_sof   <= v_q & sof_q;
            out_eof   <= v_q & eof_q;
            if (v_q) begin
                p <= a_ext * b_ext;
            end
        end
    end

endmodule

// File: rtl/sine_mix_framer.sv
// rtl/sine_mix_framer.sv - mixes ADC samples with a sine reference and frames the products for an averager
module sine_mix_framer
    import sine_mix_pkg::*;
#(
    parameter int                   ADC_WIDTH    = 16,
    parameter int                   REF_WIDTH    = 32,
    parameter int                   C_DATA_WIDTH = 48,
    parameter logic [CNT_WIDTH-1:0] FRAME_LEN    = 10'd1000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [ADC_WIDTH-1:0]    adc_data,
    input  logic signed [REF_WIDTH-1:0]    ref_data,
    input  logic                           adc_valid,
    input  logic                           frame_start,
    input  logic                           cont_mode,
    output logic signed [C_DATA_WIDTH-1:0] DATA_out,
    output logic                           DATA_out_valid,
    output logic                           DATA_sof,
    output logic                           DATA_eof,
    input  logic                           DATA_out_ready,
    output logic                           busy,
    output logic [15:0]                    drop_count
);

    if (C_DATA_WIDTH != ADC_WIDTH + REF_WIDTH) begin : g_bad_width
        $error("C_DATA_WIDTH must equal ADC_WIDTH + REF_WIDTH");
    end
    if (FRAME_LEN < FRAME_LEN_MIN || FRAME_LEN > FRAME_LEN_MAX) begin : g_bad_len
        $error("FRAME_LEN outside legal range");
    end

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 eof_done;
    logic                 accept;
    logic                 first;
    logic                 last;

    assign accept = (state == RUN) && adc_valid;
    assign first  = (cnt == '0);
    assign last   = (cnt == FRAME_LEN - 10'd1);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            eof_done   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (adc_valid && state != RUN && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if ((frame_start || cont_mode) && DATA_out_ready) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (adc_valid) begin
                        cnt <= cnt + 10'd1;
                        if (last) begin
                            state    <= DRAIN;
                            eof_done <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The averager drops ready only after it has seen eof, so both must be observed.
                    if (DATA_eof) begin
                        eof_done <= 1'b1;
                    end
                    if (eof_done && !DATA_out_ready) begin
                        state    <= WAIT;
                        eof_done <= 1'b0;
                    end
                end
                WAIT: begin
                    if (DATA_out_ready) begin
                        state <= cont_mode ? RUN : IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    signed_mult_pipe #(
        .A_WIDTH (ADC_WIDTH),
        .B_WIDTH (REF_WIDTH),
        .P_WIDTH (C_DATA_WIDTH)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (adc_data),
        .b         (ref_data),
        .in_valid  (accept),
        .in_sof    (first),
        .in_eof    (last),
        .p         (DATA_out),
        .out_valid (DATA_out_valid),
        .out_sof   (DATA_sof),
        .out_eof   (DATA_eof)
    );

endmodule

// File: tb/tb_sine_mix_framer.sv
// tb/tb_sine_mix_framer.sv - directed self-checking bench for sine_mix_framer with FRAME_LEN=4
module tb_sine_mix_framer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] adc_data = '0;
    logic signed [31:0] ref_data = '0;
    logic               adc_valid = 1'b0;
    logic               frame_start = 1'b0;
    logic               cont_mode = 1'b0;
    logic               DATA_out_ready = 1'b1;
    logic signed [47:0] DATA_out;
    logic               DATA_out_valid;
    logic               DATA_sof;
    logic               DATA_eof;
    logic               busy;
    logic [15:0]        drop_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sine_mix_framer #(
        .ADC_WIDTH    (16),
        .REF_WIDTH    (32),
        .C_DATA_WIDTH (48),
        .FRAME_LEN    (10'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_data       (adc_data),
        .ref_data       (ref_data),
        .adc_valid      (adc_valid),
        .frame_start    (frame_start),
        .cont_mode      (cont_mode),
        .DATA_out       (DATA_out),
        .DATA_out_valid (DATA_out_valid),
        .DATA_sof       (DATA_sof),
        .DATA_eof       (DATA_eof),
        .DATA_out_ready (DATA_out_ready),
        .busy           (busy),
        .drop_count     (drop_count)
    );

    typedef struct {
        logic signed [15:0] a;
        logic signed [31:0] r;
        logic signed [47:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 48'(DATA_out_valid), 48'd0);
        chk({tag, "_sof"},   48'(DATA_sof),       48'd0);
        chk({tag, "_eof"},   48'(DATA_eof),       48'd0);
        chk({tag, "_data"},  DATA_out,            48'd0);
        chk({tag, "_busy"},  48'(busy),           48'd0);
        chk({tag, "_drop"},  48'(drop_count),     48'd0);
    endtask

    int pat[7];
    int nvalid;

    initial begin
        vecs[0] = '{16'sd3,    -32'sd5,        -48'sd15};
        vecs[1] = '{16'h8000,  32'h8000_0000,  48'h4000_0000_0000};
        vecs[2] = '{16'hFFFF,  32'hFFFF_FFFF,  48'sd1};
        vecs[3] = '{16'h7FFF,  32'h7FFF_FFFF,  48'sd70366596661249};
        vecs[4] = '{16'h8000,  32'h7FFF_FFFF,  -48'sd70368744144896};
        vecs[5] = '{16'sd100,  -32'sd1000,     -48'sd100000};
        vecs[6] = '{16'sd0,    32'sd5,         48'sd0};
        vecs[7] = '{-16'sd7,   32'sd13,        -48'sd91};
        pat = '{1, 0, 0, 1, 1, 0, 1};

        // Reset state, with inputs active to show they are ignored
        adc_valid = 1'b1;
        frame_start = 1'b1;
        repeat (3) cyc();
        chk_all_zero("reset");
        adc_valid = 1'b0;
        frame_start = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Table-driven frames: 8 products over two single-shot frames
        for (int f = 0; f < 2; f++) begin
            frame_start = 1'b1;
            DATA_out_ready = 1'b1;
            cyc();
            frame_start = 1'b0;
            chk("arm_busy", 48'(busy), 48'd1);
            for (int i = 0; i < 6; i++) begin
                if (i < 4) begin
                    adc_valid = 1'b1;
                    adc_data = vecs[f*4+i].a;
                    ref_data = vecs[f*4+i].r;
                end else begin
                    adc_valid = 1'b0;
                end
                cyc();
                if (i == 0 || i == 5) begin
                    chk("tbl_idle_valid", 48'(DATA_out_valid), 48'd0);
                end else begin
                    chk("tbl_valid", 48'(DATA_out_valid), 48'd1);
                    chk("tbl_data", DATA_out, vecs[f*4+i-1].p);
                    chk("tbl_sof", 48'(DATA_sof), 48'(i == 1));
                    chk("tbl_eof", 48'(DATA_eof), 48'(i == 4));
                end
            end
            DATA_out_ready = 1'b0;
            adc_valid = 1'b1;
            repeat (3) cyc();
            adc_valid = 1'b0;
            DATA_out_ready = 1'b1;
            cyc();
            chk("tbl_back_idle", 48'(busy), 48'd0);
            chk("tbl_drop", 48'(drop_count), 48'(3 * (f + 1)));
        end

        // Gapped input with a stray frame_start mid-frame
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 7) begin
                adc_valid = pat[i][0];
                adc_data = 16'(i + 1);
                ref_data = 32'sd2;
            end else begin
                adc_valid = 1'b0;
            end
            frame_start = (i == 1);
            cyc();
            nvalid += int'(DATA_out_valid);
            if (i == 0 || i == 8) begin
                chk("gap_none", 48'(DATA_out_valid), 48'd0);
            end else begin
                chk("gap_valid", 48'(DATA_out_valid), 48'(pat[i-1]));
                if (pat[i-1] == 1) begin
                    chk("gap_data", DATA_out, 48'(2 * i));
                    chk("gap_sof", 48'(DATA_sof), 48'(i == 1));
                    chk("gap_eof", 48'(DATA_eof), 48'(i == 7));
                end else begin
                    chk("gap_tags", 48'({DATA_sof, DATA_eof}), 48'd0);
                end
            end
        end
        frame_start = 1'b0;
        chk("gap_count", 48'(nvalid), 48'd4);
        DATA_out_ready = 1'b0;
        cyc();
        cyc();
        DATA_out_ready = 1'b1;
        cyc();
        chk("gap_back_idle", 48'(busy), 48'd0);
        chk("gap_drop", 48'(drop_count), 48'd6);

        // Continuous mode with a 20-cycle ready-low window
        cont_mode = 1'b1;
        cyc();
        chk("cont_busy", 48'(busy), 48'd1);
        for (int i = 0; i < 6; i++) begin
            adc_valid = (i < 4);
            adc_data = 16'sd2;
            ref_data = 32'sd3;
            cyc();
            if (i == 1) chk("cont_sof", 48'({DATA_out_valid, DATA_sof, DATA_eof}), 48'b110);
            if (i == 4) chk("cont_eof", 48'({DATA_out_valid, DATA_sof, DATA_eof}), 48'b101);
        end
        DATA_out_ready = 1'b0;
        adc_valid = 1'b1;
        repeat (20) cyc();
        chk("wait_busy", 48'(busy), 48'd1);
        chk("wait_no_out", 48'(DATA_out_valid), 48'd0);
        chk("wait_drop", 48'(drop_count), 48'd26);
        adc_valid = 1'b0;
        DATA_out_ready = 1'b1;
        cyc();
        adc_valid = 1'b1;
        adc_data = 16'sd5;
        ref_data = -32'sd2;
        cyc();
        cyc();
        chk("rearm_sof", 48'({DATA_out_valid, DATA_sof, DATA_eof}), 48'b110);
        chk("rearm_data", DATA_out, -48'sd10);

        // Reset mid-frame with the second sample still in the pipeline
        rst_n = 1'b0;
        adc_valid = 1'b0;
        cont_mode = 1'b0;
        #1;
        chk_all_zero("midrst");
        cyc();
        chk("midrst_eof", 48'({DATA_out_valid, DATA_eof}), 48'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_quiet", 48'({DATA_out_valid, DATA_eof}), 48'd0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            adc_valid = (i < 4);
            adc_data = -16'sd3;
            ref_data = -32'sd4;
            cyc();
            if (i == 1) chk("fresh_sof", 48'({DATA_out_valid, DATA_sof, DATA_eof}), 48'b110);
            if (i == 2) chk("fresh_data", DATA_out, 48'sd12);
            if (i == 4) chk("fresh_eof", 48'({DATA_out_valid, DATA_sof, DATA_eof}), 48'b101);
        end
        chk("fresh_drop", 48'(drop_count), 48'd0);
        DATA_out_ready = 1'b0;
        cyc();
        DATA_out_ready = 1'b1;
        cyc();
        chk("fresh_back_idle", 48'(busy), 48'd0);

        // Drop counter saturation while idle
        adc_valid = 1'b1;
        repeat (65534) cyc();
        chk("sat_below", 48'(drop_count), 48'h00_0000_FFFE);
        repeat (70000 - 65534) cyc();
        chk("sat_hold", 48'(drop_count), 48'h00_0000_FFFF);
        chk("sat_idle", 48'(busy), 48'd0);
        adc_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sine_mix_framer.md
SINE_MIX_FRAMER -- requirements
Module: sine_mix_framer

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  - ADC_WIDTH, 16, signed ADC sample width.
  - REF_WIDTH, 32, signed sine reference width.
  - C_DATA_WIDTH, 48, product width; SHALL equal ADC_WIDTH+REF_WIDTH.
  - FRAME_LEN, 10'd1000, samples per frame; legal range 2..1023.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  input  1  sole clock, all logic on rising edge.
  - rst_n  input  1  asynchronous active-low reset.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
  - adc_data  input  ADC_WIDTH  signed ADC sample.
  - ref_data  input  REF_WIDTH  signed sine reference, sample-aligned with adc_data.
  - adc_valid  input  1  qualifies adc_data/ref_data; no backpressure on this side.
  - frame_start  input  1  single-cycle pulse that arms one frame.
  - cont_mode  input  1  1 = re-arm automatically after each frame.
  - DATA_out  output  C_DATA_WIDTH  signed product adc_data*ref_data.
  - DATA_out_valid  output  1  qualifies DATA_out.
  - DATA_sof  output  1  first sample of the frame, coincident with valid.
  - DATA_eof  output  1  last sample of the frame, coincident with valid.
  - DATA_out_ready  input  1  averager ready (low from the cycle after eof until its result is valid).
  - busy  output  1  state is not IDLE.
  - drop_count  output  16  saturating count of discarded input samples.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN and WAIT.
REQ-005 IDLE SHALL go to RUN when (frame_start or cont_mode) and DATA_out_ready are both 1.
REQ-006 In RUN, each adc_valid sample SHALL be accepted.
  - Sample counter: 1 on the first accepted sample, incremented on each subsequent one.
  - Accepting sample FRAME_LEN SHALL move the FSM to DRAIN.
REQ-007 DRAIN SHALL go to WAIT once the eof-tagged result has left the pipeline and DATA_out_ready has been sampled low.
REQ-008 WAIT SHALL go to RUN when DATA_out_ready is 1 and cont_mode is 1, and to IDLE when DATA_out_ready is 1 and cont_mode is 0.
REQ-009 adc_valid samples arriving in IDLE, DRAIN or WAIT SHALL be discarded and SHALL increment drop_count, saturating at 16'hFFFF.
REQ-010 Datapath SHALL be a 2-stage pipeline.
  - Stage 1 registers the operands and the sof/eof tags.
  - Stage 2 registers the full-precision signed product.
  - DATA_out_valid SHALL assert exactly 2 cycles after the accepting adc_valid.
REQ-011 DATA_out SHALL be the exact two's-complement product, with no truncation or rounding.
  - -32768 * -2147483648 = +2^46, which SHALL fit.
REQ-012 DATA_sof and DATA_eof SHALL be 0 whenever DATA_out_valid is 0.
REQ-013 Each frame SHALL contain exactly FRAME_LEN valid outputs: one sof on the first, one eof on the last.
  - Gaps in adc_valid SHALL produce gaps in DATA_out_valid and SHALL NOT break the frame.
REQ-014 A frame_start pulse received in RUN, DRAIN or WAIT SHALL be ignored.
REQ-015 No sof SHALL be emitted while DATA_out_ready is 0.

Reset
REQ-016 On rst_n low, all outputs SHALL read 0 and the FSM SHALL be IDLE.
  - DATA_out_valid, DATA_sof, DATA_eof, DATA_out, busy and drop_count all 0.
  - Pipeline valids and the sample counter cleared.
REQ-017 Reset mid-frame SHALL abandon the frame.
  - No eof is emitted.
  - After release, the next frame SHALL start with a fresh sof.

Structure
REQ-018 The FSM state encoding and the FRAME_LEN legal-range constants SHALL live in a shared package, sine_mix_pkg.
REQ-019 The 2-stage signed multiplier SHALL be one sub-module, signed_mult_pipe (parameterised widths, valid and tag sideband).

Verification (FRAME_LEN=4 unless stated)
REQ-020 Continuous sample stream:
  - Stimulus: frame_start; adc_valid every cycle; adc_data=3, ref_data=-5; ready held 1.
  - Response: 4 outputs of -15, sof on the 1st, eof on the 4th, first valid 2 cycles after the first accepted sample.
REQ-021 Extreme operands:
  - Stimulus: adc_data=16'h8000, ref_data=32'h80000000.
  - Response: DATA_out=48'h4000_0000_0000.
REQ-022 Ready handshake:
  - Stimulus: cont_mode=1; ready falls 1 cycle after eof and rises 20 cycles later.
  - Response: FSM passes DRAIN->WAIT; samples arriving in those 20 cycles are counted in drop_count; next sof follows ready high.
REQ-023 Gapped input:
  - Stimulus: adc_valid pattern 1,0,0,1,1,0,1.
  - Response: exactly 4 outputs, eof on the 7th input cycle + 2.
REQ-024 Reset mid-frame:
  - Stimulus: rst_n low after the 2nd sample, then a new frame_start.
  - Response: no eof from the abandoned frame; all outputs 0 during reset; fresh sof; drop_count = 0.
REQ-025 Drop counter saturation:
  - Stimulus: 70000 adc_valid cycles while IDLE.
  - Response: drop_count saturates at 16'hFFFF.
